// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared state, operation and width definitions for the ALU operand loader
package alu_defs_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'd0,
        S_LOAD_B  = 2'd1,
        S_LOAD_OP = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, debounce counter and rising-edge pulse for one button
//
// Ports:
//   clk    in   1  system clock
//   rst_n  in   1  asynchronous active-low reset
//   raw    in   1  raw, bouncy, asynchronous button input
//   level  out  1  debounced button level
//   rise   out  1  one-cycle pulse on each 0->1 change of level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The counter tracks consecutive cycles in which the synced input
    // disagrees with the accepted level. It is cleared on acceptance, so it
    // never exceeds CNT_LAST and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - button-stepped A/B/op loader feeding a 2-operation ALU
//
// Ports:
//   clk       in   1      system clock
//   rst_n     in   1      asynchronous active-low reset
//   sw        in   WIDTH  raw slide switches
//   btn_next  in   1      raw push button, advances the sequence
//   btn_clr   in   1      raw push button, clears the sequence
//   A         out  WIDTH  operand A
//   B         out  WIDTH  operand B
//   c         out  1      0 = A+B, 1 = A-B
//   valid     out  1      high while in S_RUN
//   state     out  2      current state for the LEDs
module alu_operand_loader
    import alu_defs_pkg::*;
#(
    parameter int WIDTH           = ALU_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_next,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             c,
    output logic             valid,
    output logic [1:0]       state
);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic             step;
    logic             clr;
    logic             unused_next_level;
    logic             unused_clr_level;

    state_t state_q;
    state_t state_d;
    logic   load_a;
    logic   load_b;
    logic   load_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next),
        .level (unused_next_level),
        .rise  (step)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clr),
        .level (unused_clr_level),
        .rise  (clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // clr has priority; a step arriving with it is dropped.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_LOAD_A;
        end else if (step) begin
            case (state_q)
                S_LOAD_A:  state_d = S_LOAD_B;
                S_LOAD_B:  state_d = S_LOAD_OP;
                S_LOAD_OP: state_d = S_RUN;
                S_RUN:     state_d = S_LOAD_A;
                default:   state_d = S_LOAD_A;
            endcase
        end
    end

    always_comb begin
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        if (step && !clr) begin
            load_a  = (state_q == S_LOAD_A);
            load_b  = (state_q == S_LOAD_B);
            load_op = (state_q == S_LOAD_OP);
        end
    end

    // Leaving S_RUN only drops valid; A, B and c are kept for display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A     <= '0;
            B     <= '0;
            c     <= OP_ADD;
            valid <= 1'b0;
        end else if (clr) begin
            A     <= '0;
            B     <= '0;
            c     <= OP_ADD;
            valid <= 1'b0;
        end else begin
            if (load_a) A <= sw_sync;
            if (load_b) B <= sw_sync;
            if (load_op) c <= sw_sync[0];
            valid <= (state_d == S_RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - randomized self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] A;
    logic [3:0] B;
    logic       c;
    logic       valid;
    logic [1:0] state;

    int n_cmp;
    int n_fail;

    // Reference: the user-visible sequence as a phase counter plus stored values.
    int         m_phase;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_c;

    alu_operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_next (btn_next),
        .btn_clr  (btn_clr),
        .A        (A),
        .B        (B),
        .c        (c),
        .valid    (valid),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model_vec();
        logic [1:0] st;
        st = 2'(m_phase % 4);
        return {st, (m_phase % 4) == 3, m_c, m_a, m_b};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {state, valid, c, A, B};
    endfunction

    task automatic model_clear();
        m_phase = 0;
        m_a = 4'h0;
        m_b = 4'h0;
        m_c = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] v);
        case (m_phase % 4)
            0: m_a = v;
            1: m_b = v;
            2: m_c = v[0];
            default: ;
        endcase
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_next(input logic [3:0] v, input int hold);
        sw = v;
        btn_next = 1'b1;
        repeat (hold) tick();
        btn_next = 1'b0;
        repeat (12) tick();
        model_step(v);
    endtask

    task automatic press_clr(input int hold);
        btn_clr = 1'b1;
        repeat (hold) tick();
        btn_clr = 1'b0;
        repeat (12) tick();
        model_clear();
    endtask

    task automatic test_reset();
        press_next(4'h7, 10);
        press_next(4'hE, 10);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, dut_vec(), 12'h000);
            end
        end
        rst_n = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_sequence();
        logic [3:0] alu;
        press_next(4'h5, 10);
        press_next(4'h3, 10);
        press_next(4'h1, 10);
        n_cmp++;
        if (dut_vec() !== {2'd3, 1'b1, 1'b1, 4'h5, 4'h3} || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL sequence got=%h exp=%h", dut_vec(), model_vec());
        end
        alu = c ? (A - B) : (A + B);
        n_cmp++;
        if (alu !== 4'h2) begin
            n_fail++;
            $display("FAIL alu_result got=%h exp=2", alu);
        end
    endtask

    task automatic test_bounce();
        int first;
        press_clr(10);
        sw = 4'hA;
        for (int k = 0; k < 2; k++) begin
            btn_next = 1'b1;
            repeat (2) tick();
            btn_next = 1'b0;
            repeat (2) tick();
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce_no_step got=%0d exp=0", state);
        end
        btn_next = 1'b1;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (first < 0 && state !== 2'd0) first = i;
        end
        n_cmp++;
        if (first < 6 || first > 8) begin
            n_fail++;
            $display("FAIL bounce_latency got=%0d exp=6..8", first);
        end
        btn_next = 1'b0;
        repeat (12) tick();
        model_step(4'hA);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL bounce_one_step got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_hold();
        press_next(4'h6, 100);
        repeat (8) tick();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL long_hold got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_clr_step();
        press_clr(10);
        press_next(4'hB, 10);
        press_next(4'hC, 10);
        n_cmp++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL clr_setup got=%0d exp=2", state);
        end
        sw = 4'hF;
        btn_next = 1'b1;
        btn_clr = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        btn_clr = 1'b0;
        repeat (12) tick();
        model_clear();
        n_cmp++;
        if (dut_vec() !== 12'h000) begin
            n_fail++;
            $display("FAIL clr_wins got=%h exp=%h", dut_vec(), 12'h000);
        end
    endtask

    task automatic test_wrap();
        press_clr(10);
        press_next(4'h5, 10);
        press_next(4'h3, 10);
        press_next(4'h1, 10);
        press_next(4'h8, 10);
        n_cmp++;
        if (dut_vec() !== {2'd0, 1'b0, 1'b1, 4'h5, 4'h3}) begin
            n_fail++;
            $display("FAIL wrap got=%h exp=%h", dut_vec(), {2'd0, 1'b0, 1'b1, 4'h5, 4'h3});
        end
        press_next(4'h9, 10);
        n_cmp++;
        if (dut_vec() !== {2'd1, 1'b0, 1'b1, 4'h9, 4'h3}) begin
            n_fail++;
            $display("FAIL wrap_reload got=%h exp=%h", dut_vec(), {2'd1, 1'b0, 1'b1, 4'h9, 4'h3});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                press_clr(int'($urandom_range(8, 20)));
            end else begin
                press_next(4'($urandom), int'($urandom_range(8, 20)));
            end
            sw = 4'($urandom);
            repeat (3) tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random op=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_clear();
        rst_n = 1'b0;
        sw = 4'h0;
        btn_next = 1'b0;
        btn_clr = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dut_vec() !== 12'h000) begin
            n_fail++;
            $display("FAIL power_on_reset got=%h exp=%h", dut_vec(), 12'h000);
        end
        rst_n = 1'b1;
        tick();
        test_reset();
        test_sequence();
        test_bounce();
        test_hold();
        test_clr_step();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
